// File: rtl/egcd_pkg.sv
// Shared types for the extended-GCD polynomial division sequencer.
package egcd_pkg;

    localparam int unsigned DEG_W = 11;

    typedef logic [DEG_W-1:0] deg_t;

    localparam deg_t MAXDEG_DEFAULT = 11'd676;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        CHK,
        FRAC,
        QWR,
        SUB,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/egcd_wdog.sv
// Wait-state watchdog: counts cycles spent in one wait state and flags the limit.
module egcd_wdog #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic restart,
    output logic timeout_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // Counter restarts on every state change, so each wait state gets a fresh budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !active) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign timeout_c = active && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/egcd_div_seq.sv
// Polynomial division sequencer for the extended-GCD datapath.
// Optional wait-state watchdog is enabled by defining WATCHDOG_EN.
module egcd_div_seq
    import egcd_pkg::*;
#(
    parameter deg_t        MAXDEG   = MAXDEG_DEFAULT,
    parameter int unsigned WD_LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  deg_t deg_n,
    input  deg_t deg_d,
    input  logic lead_d_zero,
    output logic reset_start,
    input  logic reset_done,
    output logic frac_start,
    input  logic frac_done,
    output logic sub_start,
    input  logic sub_done,
    input  deg_t sub_deg,
    output logic q_we,
    output deg_t q_addr,
    output deg_t deg_q,
    output deg_t deg_r,
    output logic busy,
    output logic div_done,
    output logic err
);

    state_t state, state_nxt;
    deg_t   deg_d_q, deg_d_nxt;
    deg_t   deg_r_nxt, deg_q_nxt, q_addr_nxt;
    logic   err_nxt;
    logic   wd_timeout;

`ifdef WATCHDOG_EN
    logic wd_active;
    logic wd_restart;

    assign wd_active  = (state == CLR) || (state == FRAC) || (state == SUB);
    assign wd_restart = (state_nxt != state);

    egcd_wdog #(
        .LIMIT(WD_LIMIT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (wd_active),
        .restart  (wd_restart),
        .timeout_c(wd_timeout)
    );
`else
    // WD_LIMIT has no effect without the watchdog; waits are unbounded.
    logic wd_unused;
    assign wd_unused  = (WD_LIMIT == 0);
    assign wd_timeout = 1'b0;
`endif

    // Next state; a done seen while its own start pulse is still high is ignored.
    always_comb begin
        state_nxt  = state;
        deg_r_nxt  = deg_r;
        deg_d_nxt  = deg_d_q;
        deg_q_nxt  = deg_q;
        q_addr_nxt = q_addr;
        err_nxt    = err;
        case (state)
            IDLE: begin
                if (start) begin
                    deg_r_nxt = deg_n;
                    deg_d_nxt = deg_d;
                    deg_q_nxt = '0;
                    err_nxt   = 1'b0;
                    state_nxt = (lead_d_zero || (deg_n > MAXDEG) || (deg_d > MAXDEG)) ? ERR : CLR;
                end
            end
            CLR: begin
                if (reset_done && !reset_start) state_nxt = CHK;
            end
            CHK: begin
                state_nxt = (deg_r >= deg_d_q) ? FRAC : DONE;
            end
            FRAC: begin
                if (frac_done && !frac_start) begin
                    state_nxt  = QWR;
                    q_addr_nxt = deg_r - deg_d_q;
                end
            end
            QWR: begin
                state_nxt = SUB;
                // The first write has the highest index, which is the quotient degree.
                if (q_addr > deg_q) deg_q_nxt = q_addr;
            end
            SUB: begin
                if (sub_done && !sub_start) begin
                    deg_r_nxt = sub_deg;
                    state_nxt = (sub_deg >= deg_r) ? ERR : CHK;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (wd_timeout) state_nxt = ERR;
        if (state_nxt == ERR) err_nxt = 1'b1;
    end

    // State, degree registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            deg_r       <= '0;
            deg_d_q     <= '0;
            deg_q       <= '0;
            q_addr      <= '0;
            q_we        <= 1'b0;
            reset_start <= 1'b0;
            frac_start  <= 1'b0;
            sub_start   <= 1'b0;
            busy        <= 1'b0;
            div_done    <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            deg_r       <= deg_r_nxt;
            deg_d_q     <= deg_d_nxt;
            deg_q       <= deg_q_nxt;
            q_addr      <= q_addr_nxt;
            q_we        <= (state_nxt == QWR);
            reset_start <= (state_nxt == CLR)  && (state != CLR);
            frac_start  <= (state_nxt == FRAC) && (state != FRAC);
            sub_start   <= (state_nxt == SUB)  && (state != SUB);
            busy        <= (state_nxt != IDLE);
            div_done    <= (state_nxt == DONE) || (state_nxt == ERR);
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_egcd_div_seq.sv
// Randomized self-checking bench for egcd_div_seq against a degree-level division model.
module tb_egcd_div_seq;
    import egcd_pkg::*;

    localparam deg_t MAXD = 11'd676;

    logic clk = 1'b0;
    logic rst_n, start, lead_d_zero;
    logic reset_done, frac_done, sub_done;
    deg_t deg_n, deg_d, sub_deg;
    logic reset_start, frac_start, sub_start, q_we, busy, div_done, err;
    deg_t q_addr, deg_q, deg_r;

    int   checks   = 0;
    int   failures = 0;
    int   rs_cnt   = 0;
    int   wait_cyc;
    bit   frac_en  = 1'b1;
    bit   glitch   = 1'b0;
    deg_t resp_q[$];
    deg_t wr_q[$];

    always #5 clk = ~clk;

    egcd_div_seq #(
        .MAXDEG  (MAXD),
        .WD_LIMIT(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .deg_n      (deg_n),
        .deg_d      (deg_d),
        .lead_d_zero(lead_d_zero),
        .reset_start(reset_start),
        .reset_done (reset_done),
        .frac_start (frac_start),
        .frac_done  (frac_done),
        .sub_start  (sub_start),
        .sub_done   (sub_done),
        .sub_deg    (sub_deg),
        .q_we       (q_we),
        .q_addr     (q_addr),
        .deg_q      (deg_q),
        .deg_r      (deg_r),
        .busy       (busy),
        .div_done   (div_done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: records quotient writes and clear-engine pulses.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (q_we) wr_q.push_back(q_addr);
            if (reset_start) rs_cnt++;
        end
    end

    // Clear-engine responder.
    initial begin
        reset_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_start) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                reset_done = 1'b1;
                @(negedge clk);
                reset_done = 1'b0;
            end
        end
    end

    // Fraction-unit responder; can be silenced to stall the sequencer.
    initial begin
        frac_done = 1'b0;
        forever begin
            @(negedge clk);
            if (frac_start && frac_en) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                frac_done = 1'b1;
                @(negedge clk);
                frac_done = 1'b0;
            end
        end
    end

    // Subtractor responder; in glitch mode it also fires a bogus done alongside sub_start.
    initial begin
        sub_done = 1'b0;
        sub_deg  = '0;
        forever begin
            @(negedge clk);
            if (sub_start) begin
                if (glitch) begin
                    sub_done = 1'b1;
                    sub_deg  = '1;
                    @(negedge clk);
                    sub_done = 1'b0;
                end
                repeat ($urandom_range(1, 3)) @(negedge clk);
                sub_deg  = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
                sub_done = 1'b1;
                @(negedge clk);
                sub_done = 1'b0;
                sub_deg  = deg_t'($urandom);
            end
        end
    end

    // One division: predict from degrees and subtractor replies, run it, compare.
    task automatic run_job(input string tag, input deg_t dn, input deg_t dd, input logic lz);
        deg_t exp_wr[$];
        deg_t r, nx, exp_dq;
        bit   start_err, exp_err;
        int   k, lat;
        start_err = lz || (dn > MAXD) || (dd > MAXD);
        exp_err   = start_err;
        r         = dn;
        k         = 0;
        if (!start_err) begin
            while (r >= dd) begin
                exp_wr.push_back(r - dd);
                nx = (k < resp_q.size()) ? resp_q[k] : '0;
                k++;
                if (nx >= r) begin
                    exp_err = 1'b1;
                    r = nx;
                    break;
                end
                r = nx;
            end
        end
        exp_dq = (dn >= dd) ? deg_t'(dn - dd) : '0;

        wr_q.delete();
        rs_cnt      = 0;
        deg_n       = dn;
        deg_d       = dd;
        lead_d_zero = lz;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        deg_n       = deg_t'($urandom);
        deg_d       = deg_t'($urandom_range(0, 3));
        lead_d_zero = 1'b1;
        lat         = 1;
        while (!div_done && lat < 3000) begin
            start = (lat == 3) && busy;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, ":done_seen"}, div_done, 1);
        if (start_err) check({tag, ":err_latency"}, lat, 1);
        check({tag, ":err_at_done"}, err, exp_err);
        @(negedge clk);
        check({tag, ":done_pulse"}, div_done, 0);
        check({tag, ":idle_busy"}, busy, 0);
        check({tag, ":err_sticky"}, err, exp_err);
        check({tag, ":reset_start_cnt"}, rs_cnt, start_err ? 0 : 1);
        check({tag, ":q_we_cnt"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
            check({tag, ":q_addr"}, wr_q[i], exp_wr[i]);
        if (!start_err) check({tag, ":deg_q"}, deg_q, exp_dq);
        if (!exp_err || start_err) check({tag, ":deg_r"}, deg_r, r);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        deg_t dn, dd, r, nx;
        logic lz;
        rst_n       = 1'b0;
        start       = 1'b0;
        deg_n       = '0;
        deg_d       = '0;
        lead_d_zero = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctl", {reset_start, frac_start, sub_start, q_we, busy, div_done, err}, 0);
        check("reset_deg", {q_addr, deg_q, deg_r}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        resp_q = {11'd4, 11'd3, 11'd1};
        run_job("div_5_2", 11'd5, 11'd2, 1'b0);
        resp_q.delete();
        run_job("div_1_3", 11'd1, 11'd3, 1'b0);
        run_job("lead_zero", 11'd5, 11'd2, 1'b1);
        resp_q = {11'd5};
        run_job("no_progress", 11'd5, 11'd2, 1'b0);
        resp_q = {11'd0};
        run_job("max_deg", MAXD, MAXD, 1'b0);
        run_job("dn_over_max", 11'd677, 11'd2, 1'b0);
        run_job("dd_over_max", 11'd2, 11'd677, 1'b0);

        // Abort during FRAC by reset, then run a fresh division.
        frac_en = 1'b0;
        resp_q.delete();
        deg_n       = 11'd5;
        deg_d       = 11'd2;
        lead_d_zero = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_cyc = 0;
        while (!frac_start && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("abort:frac_start", frac_start, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort:ctl", {reset_start, frac_start, sub_start, q_we, busy, div_done, err}, 0);
        check("abort:deg", {q_addr, deg_q, deg_r}, 0);
        @(negedge clk);
        check("abort:no_done", div_done, 0);
        rst_n   = 1'b1;
        frac_en = 1'b1;
        @(negedge clk);
        check("abort:after_release", {busy, div_done}, 0);
        resp_q = {11'd1};
        run_job("after_reset_2_2", 11'd2, 11'd2, 1'b0);

        for (int j = 0; j < 40; j++) begin
            dn     = deg_t'($urandom_range(0, 60));
            dd     = deg_t'($urandom_range(0, 20));
            lz     = ($urandom_range(0, 15) == 0);
            glitch = 1'($urandom_range(0, 1));
            resp_q.delete();
            r = dn;
            while (r >= dd) begin
                if (r == 0 || $urandom_range(0, 19) == 0) begin
                    resp_q.push_back(r);
                    break;
                end
                nx = deg_t'($urandom_range(0, int'(r) - 1));
                resp_q.push_back(nx);
                r = nx;
            end
            run_job("random", dn, dd, lz);
        end
        glitch = 1'b0;

`ifdef WATCHDOG_EN
        frac_en     = 1'b0;
        deg_n       = 11'd5;
        deg_d       = 11'd2;
        lead_d_zero = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_cyc = 0;
        while (!frac_start && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("wdog:frac_start", frac_start, 1);
        repeat (15) @(negedge clk);
        check("wdog:err_early", err, 0);
        @(negedge clk);
        check("wdog:err", err, 1);
        check("wdog:div_done", div_done, 1);
        @(negedge clk);
        check("wdog:idle", busy, 0);
        frac_en = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
